// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Optional per-requester accepted-beat counters are enabled by defining WARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                        wclk,
    input  logic                        wrst,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic                        wfull_i,
    output logic                        wincr_o,
    output logic [DATA_W-1:0]           wdata_o,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic                        busy_o
`ifdef WARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]       beat_cnt_o
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]   gidx_reg, gidx_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;

    logic [DATA_W-1:0]  req_data_arr [NUM_REQ];
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               pick_found;
    logic               in_burst;
    logic               accept;
    logic               burst_end;
    int                 cand;

    assign in_burst = (state_reg == BURST) && !wrst;
    assign accept   = in_burst && !wfull_i && req_valid_i[gidx_reg];
    assign burst_end = accept &&
                       (req_last_i[gidx_reg] || (beat_cnt_reg == CNT_W'(MAX_BURST - 1)));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_data_arr[gi] = req_data_i[gi*DATA_W +: DATA_W];
            assign req_ready_o[gi]  = in_burst && !wfull_i && (gidx_reg == IDX_W'(gi));
        end
    endgenerate

    assign wincr_o = accept;
    assign wdata_o = in_burst ? req_data_arr[gidx_reg] : '0;
    assign grant_o = grant_reg;
    assign busy_o  = (state_reg == BURST);

    // Scan downward in offset so the last hit is the nearest valid index at or after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_valid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        gidx_next     = gidx_reg;
        rr_ptr_next   = rr_ptr_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next = BURST;
                    gidx_next  = pick_idx;
                    grant_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                end
            end
            BURST: begin
                if (burst_end) begin
                    state_next    = IDLE;
                    grant_next    = '0;
                    beat_cnt_next = '0;
                    rr_ptr_next   = (gidx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_reg + 1'b1;
                end else if (accept) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            gidx_reg     <= '0;
            rr_ptr_reg   <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            gidx_reg     <= gidx_next;
            rr_ptr_reg   <= rr_ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

`ifdef WARB_STATS_EN
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
            logic [15:0] stat_reg;
            always_ff @(posedge wclk) begin
                if (wrst) begin
                    stat_reg <= '0;
                end else if (accept && (gidx_reg == IDX_W'(gi)) && (stat_reg != 16'hFFFF)) begin
                    stat_reg <= stat_reg + 16'd1;
                end
            end
            assign beat_cnt_o[gi*16 +: 16] = stat_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences,
// and a randomized run against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;
    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;

    logic                      clk;
    logic                      wrst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      wfull;
    logic                      wincr;
    logic [DATA_W-1:0]         wdata;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
`ifdef WARB_STATS_EN
    logic [NUM_REQ*16-1:0]     beat_cnt;
`endif

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .wclk        (clk),
        .wrst        (wrst),
        .req_valid_i (req_valid),
        .req_last_i  (req_last),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .wfull_i     (wfull),
        .wincr_o     (wincr),
        .wdata_o     (wdata),
        .grant_o     (grant),
        .busy_o      (busy)
`ifdef WARB_STATS_EN
        ,
        .beat_cnt_o  (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        full;
        logic [3:0]  exp_grant;
        logic        exp_busy;
        logic        exp_wincr;
        logic [7:0]  exp_wdata;
        logic [3:0]  exp_ready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [31:0] d, logic f,
                                logic [3:0] g, logic b, logic w, logic [7:0] wd, logic [3:0] r);
        vec_t t;
        t.rst = 1'b0; t.valid = v; t.last = l; t.data = d; t.full = f;
        t.exp_grant = g; t.exp_busy = b; t.exp_wincr = w; t.exp_wdata = wd; t.exp_ready = r;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after it.
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic [31:0] d, input logic f);
        @(posedge clk);
        #1;
        wrst = r; req_valid = v; req_last = l; req_data = d; wfull = f;
        #3;
    endtask

    task automatic do_reset();
        drive(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
        drive(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
    endtask

    // Behavioural model: granted index (-1 when idle), round-robin start, beats in burst.
    int mg, mrr, mcnt;

    initial begin
        logic [3:0] rr_exp [10];
        logic [3:0] e_grant, e_ready;
        logic       e_busy, e_wincr, dc;
        logic [7:0] e_wdata;
        logic [3:0] rv, rl;
        logic [31:0] rd;
        logic       rf, rr;
        int n2, bad;

        wrst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
        do_reset();
        check("reset grant", {60'd0, grant}, 64'd0);
        check("reset busy/wincr/ready", {59'd0, busy, wincr, req_ready}, 64'd0);

        // Single requester 1, three beats, then rr_ptr=2 proven by a 4-way contention.
        vecs.push_back(mk(4'h2, 4'h0, 32'h0000A100, 0, 4'h0, 0, 0, 8'h00, 4'h0));
        vecs.push_back(mk(4'h2, 4'h0, 32'h0000A100, 0, 4'h2, 1, 1, 8'hA1, 4'h2));
        vecs.push_back(mk(4'h2, 4'h0, 32'h0000A200, 0, 4'h2, 1, 1, 8'hA2, 4'h2));
        vecs.push_back(mk(4'h2, 4'h2, 32'h0000A300, 0, 4'h2, 1, 1, 8'hA3, 4'h2));
        vecs.push_back(mk(4'h0, 4'h0, 32'h00000000, 0, 4'h0, 0, 0, 8'h00, 4'h0));
        vecs.push_back(mk(4'hF, 4'hF, 32'hD3D2D1D0, 0, 4'h0, 0, 0, 8'h00, 4'h0));
        vecs.push_back(mk(4'hF, 4'hF, 32'hD3D2D1D0, 0, 4'h4, 1, 1, 8'hD2, 4'h4));
        vecs.push_back(mk(4'h0, 4'h0, 32'h00000000, 0, 4'h0, 0, 0, 8'h00, 4'h0));
        // Requester 0 burst of 4 with a valid drop and a 3-cycle full stall (last ignored while stalled).
        vecs.push_back(mk(4'h1, 4'h0, 32'h000000B1, 0, 4'h0, 0, 0, 8'h00, 4'h0));
        vecs.push_back(mk(4'h1, 4'h0, 32'h000000B1, 0, 4'h1, 1, 1, 8'hB1, 4'h1));
        vecs.push_back(mk(4'h1, 4'h0, 32'h000000B2, 0, 4'h1, 1, 1, 8'hB2, 4'h1));
        vecs.push_back(mk(4'h0, 4'h1, 32'h000000B3, 0, 4'h1, 1, 0, 8'h00, 4'h1));
        vecs.push_back(mk(4'h1, 4'h1, 32'h000000B3, 1, 4'h1, 1, 0, 8'h00, 4'h0));
        vecs.push_back(mk(4'h1, 4'h1, 32'h000000B3, 1, 4'h1, 1, 0, 8'h00, 4'h0));
        vecs.push_back(mk(4'h1, 4'h1, 32'h000000B3, 1, 4'h1, 1, 0, 8'h00, 4'h0));
        vecs.push_back(mk(4'h1, 4'h0, 32'h000000B3, 0, 4'h1, 1, 1, 8'hB3, 4'h1));
        vecs.push_back(mk(4'h1, 4'h1, 32'h000000B4, 0, 4'h1, 1, 1, 8'hB4, 4'h1));
        vecs.push_back(mk(4'h0, 4'h0, 32'h00000000, 0, 4'h0, 0, 0, 8'h00, 4'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].full);
            check($sformatf("vec%0d grant", i), {60'd0, grant}, {60'd0, vecs[i].exp_grant});
            check($sformatf("vec%0d busy/wincr/ready", i), {58'd0, busy, wincr, req_ready},
                  {58'd0, vecs[i].exp_busy, vecs[i].exp_wincr, vecs[i].exp_ready});
            if (vecs[i].exp_wincr || vecs[i].exp_grant == 4'h0)
                check($sformatf("vec%0d wdata", i), {56'd0, wdata}, {56'd0, vecs[i].exp_wdata});
        end

        // Round robin from reset: all requesters valid with one-beat packets.
        rr_exp = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 4'hF, 4'hF, 32'h44332211, 1'b0);
            check($sformatf("rr%0d grant", i), {60'd0, grant}, {60'd0, rr_exp[i]});
            check($sformatf("rr%0d wincr", i), {63'd0, wincr}, {63'd0, rr_exp[i] != 4'h0});
        end

        // Forced re-arbitration: req2 streams without last, req3 waits.
        drive(1'b0, 4'b0100, 4'h0, 32'h0, 1'b0);
        check("force idle", {60'd0, grant}, 64'd0);
        n2 = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 4'b1100, 4'h0, {8'h80 + 8'(i), 8'(i), 16'h0}, 1'b0);
            if (grant == 4'b0100 && wincr) begin
                n2++;
                if (wdata != 8'(i)) bad++;
            end
            if (i == 16) check("force gap grant", {60'd0, grant}, 64'd0);
            if (i == 17) check("force next grant", {60'd0, grant}, 64'h8);
        end
        check("force req2 writes", 64'(n2), 64'd16);
        check("force req2 data errors", 64'(bad), 64'd0);

        // End req3's burst, run a req1 packet so rr_ptr=2, then reset mid-burst.
        drive(1'b0, 4'b1000, 4'b1000, 32'h99000000, 1'b0);
        check("req3 end wincr", {63'd0, wincr}, 64'd1);
        drive(1'b0, 4'b0010, 4'b0010, 32'h00005500, 1'b0);
        drive(1'b0, 4'b0010, 4'b0010, 32'h00005500, 1'b0);
        check("req1 one beat", {55'd0, wincr, wdata}, {55'd0, 1'b1, 8'h55});
        drive(1'b0, 4'b0010, 4'h0, 32'h00000100, 1'b0);
        drive(1'b0, 4'b0010, 4'h0, 32'h00000100, 1'b0);
        drive(1'b0, 4'b0010, 4'h0, 32'h00000200, 1'b0);
        check("mid beat2 wincr", {63'd0, wincr}, 64'd1);
        drive(1'b1, 4'b0010, 4'h0, 32'h00000300, 1'b0);
        check("rst outputs", {51'd0, wincr, req_ready, wdata}, 64'd0);
        drive(1'b0, 4'b1001, 4'h0, 32'h0, 1'b0);
        check("post-rst idle", {58'd0, grant, busy, wincr}, 64'd0);
        drive(1'b0, 4'b1001, 4'b1001, 32'h0, 1'b0);
        check("post-rst grant", {60'd0, grant}, 64'h1);

        // Randomized run against the behavioural model.
        do_reset();
        mg = -1; mrr = 0; mcnt = 0;
        for (int c = 0; c < 2000; c++) begin
            rr = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < NUM_REQ; b++) begin
                rv[b] = ($urandom_range(0, 9) < 7);
                rl[b] = ($urandom_range(0, 7) == 0);
            end
            rd = $urandom;
            rf = ($urandom_range(0, 4) == 0);
            drive(rr, rv, rl, rd, rf);

            e_grant = (mg >= 0) ? 4'(1 << mg) : 4'h0;
            e_busy  = (mg >= 0);
            e_ready = (mg >= 0 && !rf && !rr) ? 4'(1 << mg) : 4'h0;
            e_wincr = (mg >= 0) && !rf && !rr && rv[mg];
            e_wdata = e_wincr ? rd[mg*8 +: 8] : 8'h00;
            dc      = (mg >= 0) && !e_wincr && !rr;
            check($sformatf("rand%0d {grant,busy,ready,wincr,wdata}", c),
                  {46'd0, grant, busy, req_ready, wincr, (dc ? 8'h00 : wdata)},
                  {46'd0, e_grant, e_busy, e_ready, e_wincr, e_wdata});

            if (rr) begin
                mg = -1; mrr = 0; mcnt = 0;
            end else if (mg < 0) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (mg < 0 && rv[(mrr + k) % NUM_REQ]) mg = (mrr + k) % NUM_REQ;
                end
            end else if (e_wincr) begin
                mcnt++;
                if (rl[mg] || mcnt == MAX_BURST) begin
                    mrr = (mg + 1) % NUM_REQ; mg = -1; mcnt = 0;
                end
            end
        end

`ifdef WARB_STATS_EN
        do_reset();
        drive(1'b0, 4'b0010, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 4'b0010, (i == 4) ? 4'b0010 : 4'h0, 32'h0, 1'b0);
        drive(1'b0, 4'b1000, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) drive(1'b0, 4'b1000, (i == 1) ? 4'b1000 : 4'h0, 32'h0, 1'b0);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0);
        check("stats fields", {32'd0, beat_cnt}, {32'd0, 16'd2, 16'd0, 16'd5, 16'd0});
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
